// File: rtl/turn_controller_if.sv
// Player-facing signal bundle of the turn controller: controls and board inputs,
// shot/hit maps and result strobes back out.
interface turn_controller_if;
  localparam int unsigned CELLS = 36;

  logic             start;
  logic             fire;
  logic [CELLS-1:0] cursor;
  logic [CELLS-1:0] ships_p0;
  logic [CELLS-1:0] ships_p1;
  logic             player;
  logic [CELLS-1:0] shots_p0;
  logic [CELLS-1:0] shots_p1;
  logic [CELLS-1:0] hits_p0;
  logic [CELLS-1:0] hits_p1;
  logic             hit_pulse;
  logic             miss_pulse;
  logic             dup_pulse;
  logic             cursor_clr;
  logic             game_over;
  logic             winner;

  modport master (
    output start, fire, cursor, ships_p0, ships_p1,
    input  player, shots_p0, shots_p1, hits_p0, hits_p1,
    input  hit_pulse, miss_pulse, dup_pulse, cursor_clr, game_over, winner
  );

  modport slave (
    input  start, fire, cursor, ships_p0, ships_p1,
    output player, shots_p0, shots_p1, hits_p0, hits_p1,
    output hit_pulse, miss_pulse, dup_pulse, cursor_clr, game_over, winner
  );
endinterface

// File: rtl/turn_controller.sv
// Two-player battleship turn sequencer: aims, resolves each shot against the
// opponent's latched board, holds the result, then swaps players or ends the game.
module turn_controller #(
  parameter int unsigned HIT_TARGET    = 17,
  parameter int unsigned RESULT_CYCLES = 25000000
) (
  input logic              clk,
  input logic              reset,
  turn_controller_if.slave bus
);
  localparam int unsigned CELLS = 36;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned HCN_W = 6;
  localparam int unsigned CNT_W = 25;

  typedef enum logic [2:0] {
    S_IDLE, S_AIM, S_CHECK, S_RESULT, S_SWITCH, S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic               fire_q;
  logic [IDX_W-1:0]   target_q, target_d;
  logic [CELLS-1:0]   ships0_q, ships0_d, ships1_q, ships1_d;
  logic [CELLS-1:0]   shots0_q, shots0_d, shots1_q, shots1_d;
  logic [CELLS-1:0]   hits0_q, hits0_d, hits1_q, hits1_d;
  logic [HCN_W-1:0]   hcnt0_q, hcnt0_d, hcnt1_q, hcnt1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               player_q, player_d;
  logic               hit_q, hit_d, miss_q, miss_d, dup_q, dup_d;
  logic               cursor_clr_q, cursor_clr_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  logic               fire_edge_c;
  logic               cursor_onehot_c;
  logic [IDX_W-1:0]   cursor_idx_c;
  logic [CELLS-1:0]   target_mask_c;
  logic               already_shot_c;
  logic               opp_ship_c;
  logic               count_done_c;
  logic               win_c;

  assign fire_edge_c     = bus.fire & ~fire_q;
  assign cursor_onehot_c = (bus.cursor != '0) && ((bus.cursor & (bus.cursor - CELLS'(1))) == '0);
  assign target_mask_c   = CELLS'(1) << target_q;
  assign already_shot_c  = |((player_q ? shots1_q : shots0_q) & target_mask_c);
  assign opp_ship_c      = |((player_q ? ships0_q : ships1_q) & target_mask_c);
  assign count_done_c    = (cnt_q == CNT_W'(RESULT_CYCLES - 1));
  assign win_c           = ((player_q ? hcnt1_q : hcnt0_q) == HCN_W'(HIT_TARGET));

  // Priority-free encoder; only consumed when the cursor is one-hot
  always_comb begin
    cursor_idx_c = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (bus.cursor[i]) cursor_idx_c = IDX_W'(i);
    end
  end

  // State register plus all registered datapath/outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fire_q       <= 1'b0;
      target_q     <= '0;
      ships0_q     <= '0;
      ships1_q     <= '0;
      shots0_q     <= '0;
      shots1_q     <= '0;
      hits0_q      <= '0;
      hits1_q      <= '0;
      hcnt0_q      <= '0;
      hcnt1_q      <= '0;
      cnt_q        <= '0;
      player_q     <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      dup_q        <= 1'b0;
      cursor_clr_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fire_q       <= bus.fire;
      target_q     <= target_d;
      ships0_q     <= ships0_d;
      ships1_q     <= ships1_d;
      shots0_q     <= shots0_d;
      shots1_q     <= shots1_d;
      hits0_q      <= hits0_d;
      hits1_q      <= hits1_d;
      hcnt0_q      <= hcnt0_d;
      hcnt1_q      <= hcnt1_d;
      cnt_q        <= cnt_d;
      player_q     <= player_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      dup_q        <= dup_d;
      cursor_clr_q <= cursor_clr_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_OVER: if (bus.start) state_d = S_AIM;
      S_AIM:          if (fire_edge_c && cursor_onehot_c) state_d = S_CHECK;
      S_CHECK:        state_d = already_shot_c ? S_AIM : S_RESULT;
      S_RESULT:       if (count_done_c) state_d = win_c ? S_OVER : S_SWITCH;
      S_SWITCH:       state_d = S_AIM;
      default:        state_d = S_IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs
  always_comb begin
    target_d     = target_q;
    ships0_d     = ships0_q;
    ships1_d     = ships1_q;
    shots0_d     = shots0_q;
    shots1_d     = shots1_q;
    hits0_d      = hits0_q;
    hits1_d      = hits1_q;
    hcnt0_d      = hcnt0_q;
    hcnt1_d      = hcnt1_q;
    cnt_d        = '0;
    player_d     = player_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    dup_d        = 1'b0;
    cursor_clr_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          ships0_d     = bus.ships_p0;
          ships1_d     = bus.ships_p1;
          shots0_d     = '0;
          shots1_d     = '0;
          hits0_d      = '0;
          hits1_d      = '0;
          hcnt0_d      = '0;
          hcnt1_d      = '0;
          player_d     = 1'b0;
          cursor_clr_d = 1'b1;
        end
      end
      S_AIM: begin
        if (fire_edge_c && cursor_onehot_c) target_d = cursor_idx_c;
      end
      S_CHECK: begin
        if (already_shot_c) begin
          dup_d = 1'b1;
        end else begin
          if (player_q) shots1_d = shots1_q | target_mask_c;
          else          shots0_d = shots0_q | target_mask_c;
          if (opp_ship_c) begin
            hit_d = 1'b1;
            if (player_q) begin
              hits1_d = hits1_q | target_mask_c;
              hcnt1_d = hcnt1_q + HCN_W'(1);
            end else begin
              hits0_d = hits0_q | target_mask_c;
              hcnt0_d = hcnt0_q + HCN_W'(1);
            end
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (!count_done_c) cnt_d = cnt_q + CNT_W'(1);
      end
      S_SWITCH: begin
        player_d     = ~player_q;
        cursor_clr_d = 1'b1;
      end
      default: ;
    endcase

    // game_over/winner track the registered state so they drop as soon as a new game starts
    game_over_d = (state_d == S_OVER);
    winner_d    = (state_d == S_OVER) ? player_d : 1'b0;
  end

  assign bus.player     = player_q;
  assign bus.shots_p0   = shots0_q;
  assign bus.shots_p1   = shots1_q;
  assign bus.hits_p0    = hits0_q;
  assign bus.hits_p1    = hits1_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.dup_pulse  = dup_q;
  assign bus.cursor_clr = cursor_clr_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: a small game model predicts each shot's
// strobe and maps; a negedge monitor pops and compares whenever a strobe fires.
module tb_turn_controller;
  localparam int unsigned HIT_TARGET    = 2;
  localparam int unsigned RESULT_CYCLES = 4;

  typedef struct {
    logic [1:0]  kind;   // 1 hit, 2 miss, 3 dup
    logic        p;
    logic [35:0] shots;
    logic [35:0] hits;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [35:0] m_ships[2];
  logic [35:0] m_shots[2];
  logic [35:0] m_hits[2];
  int          m_cnt[2];
  logic        m_p;

  turn_controller_if bus ();

  turn_controller #(.HIT_TARGET(HIT_TARGET), .RESULT_CYCLES(RESULT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe monitor: every strobe must match the oldest predicted shot
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] k;
    if (bus.hit_pulse || bus.miss_pulse || bus.dup_pulse) begin
      chk("one_strobe", 36'($countones({bus.hit_pulse, bus.miss_pulse, bus.dup_pulse})), 36'd1);
      k = bus.hit_pulse ? 2'd1 : (bus.miss_pulse ? 2'd2 : 2'd3);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 36'(k), 36'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 36'(k), 36'(e.kind));
        chk("shot_map", e.p ? bus.shots_p1 : bus.shots_p0, e.shots);
        chk("hit_map",  e.p ? bus.hits_p1  : bus.hits_p0,  e.hits);
      end
    end
  end

  task automatic start_game(input logic [35:0] s0, input logic [35:0] s1);
    bus.ships_p0 = s0;
    bus.ships_p1 = s1;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.ships_p0 = '0;
    bus.ships_p1 = '0;
    m_ships[0] = s0; m_ships[1] = s1;
    m_shots[0] = '0; m_shots[1] = '0;
    m_hits[0]  = '0; m_hits[1]  = '0;
    m_cnt[0]   = 0;  m_cnt[1]   = 0;
    m_p        = 1'b0;
    chk("start_cursor_clr", 36'(bus.cursor_clr), 36'd1);
    chk("start_player", 36'(bus.player), 36'd0);
    chk("start_shots", bus.shots_p0 | bus.shots_p1, 36'd0);
    chk("start_game_over", 36'(bus.game_over), 36'd0);
    tick(1);
    chk("aim_cursor_clr", 36'(bus.cursor_clr), 36'd0);
  endtask

  // Predict, fire at idx, and advance to the cycle where the strobe is visible
  task automatic take_turn(input int idx, output logic [1:0] kind);
    exp_t        e;
    logic [35:0] m;
    m = 36'd1 << idx;
    if ((m_shots[m_p] & m) != 0) begin
      kind = 2'd3;
    end else begin
      m_shots[m_p] |= m;
      if ((m_ships[~m_p] & m) != 0) begin
        kind = 2'd1;
        m_hits[m_p] |= m;
        m_cnt[m_p]++;
      end else begin
        kind = 2'd2;
      end
    end
    e.kind = kind; e.p = m_p; e.shots = m_shots[m_p]; e.hits = m_hits[m_p];
    sb.push_back(e);
    bus.cursor = m;
    bus.fire = 1'b1;
    tick(1);
    bus.fire = 1'b0;
    tick(1);
    @(negedge clk);
    #1;
    chk("strobe_seen", 36'(sb.size()), 36'd0);
  endtask

  task automatic finish_turn(input logic [1:0] kind);
    if (kind == 2'd3) begin
      chk("dup_no_clr", 36'(bus.cursor_clr), 36'd0);
      chk("dup_player", 36'(bus.player), 36'(m_p));
      return;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("result_no_clr", 36'(bus.cursor_clr), 36'd0);
    end
    tick(1);
    if (m_cnt[m_p] == int'(HIT_TARGET)) begin
      chk("game_over", 36'(bus.game_over), 36'd1);
      chk("winner", 36'(bus.winner), 36'(m_p));
    end else begin
      chk("switch_no_over", 36'(bus.game_over), 36'd0);
      tick(1);
      m_p = ~m_p;
      chk("switch_cursor_clr", 36'(bus.cursor_clr), 36'd1);
      chk("switch_player", 36'(bus.player), 36'(m_p));
    end
  endtask

  task automatic stray_fire(input logic [35:0] c);
    bus.cursor = c;
    bus.fire = 1'b1;
    tick(1);
    bus.fire = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [1:0] k;
    bus.start = 1'b0; bus.fire = 1'b0; bus.cursor = '0;
    bus.ships_p0 = '0; bus.ships_p1 = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_player", 36'(bus.player), 36'd0);
    chk("rst_maps", bus.shots_p0 | bus.shots_p1 | bus.hits_p0 | bus.hits_p1, 36'd0);
    chk("rst_flags", 36'({bus.hit_pulse, bus.miss_pulse, bus.dup_pulse, bus.cursor_clr,
                          bus.game_over, bus.winner}), 36'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick(3);
    chk("idle_hold", 36'({bus.cursor_clr, bus.game_over, bus.player}), 36'd0);

    // Game 1: player 0 wins with hits on cells 0 and 1
    start_game(36'h30, 36'h3);
    take_turn(0, k); chk("g1_kind0", 36'(k), 36'd1); finish_turn(k);
    take_turn(2, k); finish_turn(k);
    chk("g1_hits_p1", bus.hits_p1, 36'd0);
    take_turn(0, k); chk("g1_dup", 36'(k), 36'd3); finish_turn(k);
    take_turn(1, k); finish_turn(k);
    stray_fire(36'h80);
    chk("over_shots_p0", bus.shots_p0, m_shots[0]);
    chk("over_shots_p1", bus.shots_p1, m_shots[1]);
    chk("over_held", 36'(bus.game_over), 36'd1);

    // Game 2: ignored fire cases, then player 1 wins
    start_game(36'h30, 36'h3);
    take_turn(10, k);
    bus.fire = 1'b1;
    finish_turn(k);
    tick(3);
    bus.fire = 1'b0;
    tick(1);
    stray_fire(36'h0);
    stray_fire(36'h5);
    chk("ign_shots_p1", bus.shots_p1, 36'd0);
    chk("ign_player", 36'(bus.player), 36'd1);
    take_turn(4, k);  finish_turn(k);
    take_turn(11, k); finish_turn(k);
    take_turn(5, k);  finish_turn(k);

    // Game 3: async reset in the middle of RESULT
    start_game(36'h30, 36'h3);
    take_turn(20, k); finish_turn(k);
    take_turn(4, k);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_player", 36'(bus.player), 36'd0);
    chk("mid_rst_maps", bus.shots_p0 | bus.shots_p1 | bus.hits_p1, 36'd0);
    chk("mid_rst_flags", 36'({bus.hit_pulse, bus.miss_pulse, bus.dup_pulse, bus.cursor_clr,
                              bus.game_over, bus.winner}), 36'd0);
    #3 reset = 1'b1;
    tick(RESULT_CYCLES + 3);
    chk("post_rst_idle", 36'({bus.cursor_clr, bus.game_over, bus.player}), 36'd0);
    start_game(36'h30, 36'h3);
    take_turn(0, k); chk("fresh_hit", 36'(k), 36'd1); finish_turn(k);
    chk("sb_empty", 36'(sb.size()), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
